// File: rtl/mandelbrot_calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mandelbrot_calc_pkg
//  Purpose : Fixed-point format, escape constant and FSM state type shared by
//            the Mandelbrot escape-time engine.
//  Rev     : 1.0  initial release
// ============================================================================
package mandelbrot_calc_pkg;

   localparam int FP_S    = 1;
   localparam int FP_I    = 4;
   localparam int FPW_NOM = 27;
   localparam int FP_F    = FPW_NOM - FP_S - FP_I;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // 4.0 in product format, i.e. with twice the coordinate fraction bits
   function automatic logic signed [63:0] fp_escape_const(input int frac);
      return 64'sd4 <<< (2 * frac);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mandelbrot_calc_iter.sv
`default_nettype none
// ============================================================================
//  Module  : mandelbrot_iter
//  Purpose : One combinational Mandelbrot step: z_next = z^2 + c, plus the
//            |z|^2 > 4 escape flag evaluated on the untruncated products.
//  Rev     : 1.0  initial release
// ============================================================================
module mandelbrot_iter
   import mandelbrot_calc_pkg::*;
#(
   parameter int FPW     = FPW_NOM,
   parameter int FP_FRAC = FP_F
) (
   input  logic signed [FPW+1:0] zx,
   input  logic signed [FPW+1:0] zy,
   input  logic signed [FPW-1:0] cx,
   input  logic signed [FPW-1:0] cy,
   output logic signed [FPW+1:0] zx_next,
   output logic signed [FPW+1:0] zy_next,
   output logic                  escape
);

   localparam int ZW = FPW + 2;
   localparam int PW = 2 * ZW;
   localparam logic signed [PW:0] ESC_4 = $signed((PW+1)'(fp_escape_const(FP_FRAC)));

   logic signed [PW-1:0] w_zx_e, w_zy_e;
   logic signed [PW-1:0] w_xx, w_yy, w_xy;
   logic signed [PW:0]   w_mag, w_diff;
   logic        [ZW-1:0] w_cx_e, w_cy_e;
   logic                 unused_bits;

   assign w_zx_e = {{ZW{zx[ZW-1]}}, zx};
   assign w_zy_e = {{ZW{zy[ZW-1]}}, zy};
   assign w_cx_e = {{(ZW-FPW){cx[FPW-1]}}, cx};
   assign w_cy_e = {{(ZW-FPW){cy[FPW-1]}}, cy};

   assign w_xx = w_zx_e * w_zx_e;
   assign w_yy = w_zy_e * w_zy_e;
   assign w_xy = w_zx_e * w_zy_e;

   assign w_mag  = {w_xx[PW-1], w_xx} + {w_yy[PW-1], w_yy};
   assign w_diff = {w_xx[PW-1], w_xx} - {w_yy[PW-1], w_yy};
   assign escape = (w_mag > ESC_4);

   // Bit-slicing gives floor() of the full-precision result; 2*xy is a one-bit-lower slice
   assign zx_next = w_diff[FP_FRAC +: ZW] + w_cx_e;
   assign zy_next = w_xy[FP_FRAC-1 +: ZW] + w_cy_e;

   assign unused_bits = ^{w_diff[FP_FRAC-1:0], w_diff[PW:FP_FRAC+ZW],
                          w_xy[FP_FRAC-2:0], w_xy[PW-1:FP_FRAC-1+ZW]};

endmodule
`default_nettype wire

// File: rtl/mandelbrot_calc.sv
`default_nettype none
// ============================================================================
//  Module  : mandelbrot_calc
//  Purpose : Iterative Mandelbrot escape-time engine, one point in flight,
//            valid/ready on both sides, pixel address carried through.
//  Rev     : 1.0  initial release
// ============================================================================
module mandelbrot_calc
   import mandelbrot_calc_pkg::*;
#(
   parameter int MAXITERS = 256,
   parameter int IW       = 8,
   parameter int FPW      = 27,
   parameter int AW       = 11
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clk_en,
   input  logic           in_vld,
   output logic           in_rdy,
   input  logic [FPW-1:0] x_man,
   input  logic [FPW-1:0] y_man,
   input  logic [AW-1:0]  adr_i,
   output logic           out_vld,
   input  logic           out_rdy,
   output logic [IW-1:0]  niter,
   output logic [AW-1:0]  adr_o
);

   localparam int            ZW    = FPW + 2;
   localparam int            FRAC  = FPW - FP_S - FP_I;
   localparam logic [IW-1:0] N_CAP = IW'(MAXITERS - 1);

   state_t                state_q, state_d;
   logic signed [FPW-1:0] cx_q, cx_d, cy_q, cy_d;
   logic signed [ZW-1:0]  zx_q, zx_d, zy_q, zy_d;
   logic [IW-1:0]         n_q, n_d, niter_q, niter_d;
   logic [AW-1:0]         adr_q, adr_d, adr_o_q, adr_o_d;
   logic                  in_rdy_q, in_rdy_d, out_vld_q, out_vld_d;

   logic signed [ZW-1:0]  w_zx_next, w_zy_next;
   logic                  w_escape;

   mandelbrot_iter #(
      .FPW     (FPW),
      .FP_FRAC (FRAC)
   ) u_iter (
      .zx      (zx_q),
      .zy      (zy_q),
      .cx      (cx_q),
      .cy      (cy_q),
      .zx_next (w_zx_next),
      .zy_next (w_zy_next),
      .escape  (w_escape)
   );

   always_comb begin
      state_d   = state_q;
      cx_d      = cx_q;
      cy_d      = cy_q;
      zx_d      = zx_q;
      zy_d      = zy_q;
      n_d       = n_q;
      adr_d     = adr_q;
      niter_d   = niter_q;
      adr_o_d   = adr_o_q;
      in_rdy_d  = in_rdy_q;
      out_vld_d = out_vld_q;
      if (clk_en) begin
         case (state_q)
            ST_IDLE: begin
               if (in_vld) begin
                  cx_d     = $signed(x_man);
                  cy_d     = $signed(y_man);
                  adr_d    = adr_i;
                  zx_d     = '0;
                  zy_d     = '0;
                  n_d      = '0;
                  in_rdy_d = 1'b0;
                  state_d  = ST_CALC;
               end
            end
            ST_CALC: begin
               if (w_escape || (n_q == N_CAP)) begin
                  niter_d   = n_q;
                  adr_o_d   = adr_q;
                  out_vld_d = 1'b1;
                  state_d   = ST_DONE;
               end else begin
                  zx_d = w_zx_next;
                  zy_d = w_zy_next;
                  n_d  = n_q + 1'b1;
               end
            end
            ST_DONE: begin
               if (out_rdy) begin
                  out_vld_d = 1'b0;
                  in_rdy_d  = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
            default: begin
               out_vld_d = 1'b0;
               in_rdy_d  = 1'b1;
               state_d   = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cx_q      <= '0;
         cy_q      <= '0;
         zx_q      <= '0;
         zy_q      <= '0;
         n_q       <= '0;
         adr_q     <= '0;
         niter_q   <= '0;
         adr_o_q   <= '0;
         in_rdy_q  <= 1'b1;
         out_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cx_q      <= cx_d;
         cy_q      <= cy_d;
         zx_q      <= zx_d;
         zy_q      <= zy_d;
         n_q       <= n_d;
         adr_q     <= adr_d;
         niter_q   <= niter_d;
         adr_o_q   <= adr_o_d;
         in_rdy_q  <= in_rdy_d;
         out_vld_q <= out_vld_d;
      end
   end

   assign in_rdy  = in_rdy_q;
   assign out_vld = out_vld_q;
   assign niter   = niter_q;
   assign adr_o   = adr_o_q;

endmodule
`default_nettype wire

// File: tb/tb_mandelbrot_calc.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mandelbrot_calc
//  Purpose : Self-checking bench for mandelbrot_calc against an integer
//            escape-time reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mandelbrot_calc;

   localparam int MAXITERS = 256;
   localparam int IW       = 8;
   localparam int FPW      = 27;
   localparam int AW       = 11;
   localparam int F        = 22;
   localparam int ONE      = 1 << F;

   logic           clk = 1'b0;
   logic           rst, clk_en, in_vld, out_rdy;
   logic           in_rdy, out_vld;
   logic [FPW-1:0] x_man, y_man;
   logic [AW-1:0]  adr_i, adr_o;
   logic [IW-1:0]  niter;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mandelbrot_calc #(
      .MAXITERS (MAXITERS),
      .IW       (IW),
      .FPW      (FPW),
      .AW       (AW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .clk_en  (clk_en),
      .in_vld  (in_vld),
      .in_rdy  (in_rdy),
      .x_man   (x_man),
      .y_man   (y_man),
      .adr_i   (adr_i),
      .out_vld (out_vld),
      .out_rdy (out_rdy),
      .niter   (niter),
      .adr_o   (adr_o)
   );

   // Escape-time iteration in real arithmetic scaled by 2^F, floored on writeback
   function automatic int ref_niter(input int cx, input int cy);
      longint zx = 0;
      longint zy = 0;
      longint xx, yy, xy;
      for (int n = 0; n < MAXITERS; n++) begin
         xx = zx * zx;
         yy = zy * zy;
         xy = zx * zy;
         if ((xx + yy > (longint'(4) <<< (2 * F))) || (n == MAXITERS - 1))
            return n;
         zx = ((xx - yy) >>> F) + longint'(cx);
         zy = ((2 * xy) >>> F) + longint'(cy);
      end
      return MAXITERS - 1;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Offer one point, wait for its result, check count/address/latency
   task automatic run_point(input int x, input int y, input logic [AW-1:0] adr,
                            input bit toggle_en, input string tag);
      int exp_n;
      int edges;
      bit got;
      exp_n = ref_niter(x, y);
      for (int i = 0; i < 50 && !in_rdy; i++) @(negedge clk);
      chk({tag, "_rdy"}, 64'(in_rdy), 64'd1);
      clk_en = 1'b1;
      in_vld = 1'b1;
      x_man  = x[FPW-1:0];
      y_man  = y[FPW-1:0];
      adr_i  = adr;
      @(posedge clk);
      @(negedge clk);
      in_vld = 1'b0;
      x_man  = FPW'($urandom);
      y_man  = FPW'($urandom);
      adr_i  = AW'($urandom);
      chk({tag, "_busy"}, 64'(in_rdy), 64'd0);
      edges = 1;
      got   = 1'b0;
      for (int i = 0; i < 1200; i++) begin
         if (toggle_en) clk_en = ~clk_en;
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (out_vld) begin
            got = 1'b1;
            break;
         end
      end
      clk_en = 1'b1;
      chk({tag, "_done"}, 64'(got), 64'd1);
      chk({tag, "_niter"}, 64'(niter), 64'(exp_n));
      chk({tag, "_adr"}, 64'(adr_o), 64'(adr));
      chk({tag, "_lat"}, 64'(edges), toggle_en ? 64'(2 * exp_n + 3) : 64'(exp_n + 2));
      if (out_rdy) begin
         @(posedge clk);
         @(negedge clk);
         chk({tag, "_taken"}, 64'(out_vld), 64'd0);
         chk({tag, "_idle"}, 64'(in_rdy), 64'd1);
      end
   endtask

   initial begin
      logic [AW-1:0] held_adr;
      logic [IW-1:0] held_n;
      int            rx, ry;

      rst     = 1'b1;
      clk_en  = 1'b1;
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      x_man   = '0;
      y_man   = '0;
      adr_i   = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_rdy", 64'(in_rdy), 64'd1);
      chk("rst_out_vld", 64'(out_vld), 64'd0);
      chk("rst_niter", 64'(niter), 64'd0);
      chk("rst_adr_o", 64'(adr_o), 64'd0);

      run_point(ONE, -1, 11'h123, 1'b0, "x1_yneg");
      chk("x1_yneg_n3", 64'(niter), 64'd3);
      run_point(0, 0, 11'h2A5, 1'b0, "origin_cap");
      chk("origin_cap_255", 64'(niter), 64'd255);
      run_point(2 * ONE, 0, 11'h0F0, 1'b0, "x_plus2");
      chk("x_plus2_n2", 64'(niter), 64'd2);
      run_point(-2 * ONE, 0, 11'h70F, 1'b0, "x_minus2");
      chk("x_minus2_cap", 64'(niter), 64'd255);

      // Result held under backpressure; new offers ignored while busy
      out_rdy = 1'b0;
      run_point(ONE / 2, ONE / 2, 11'h3C3, 1'b0, "stall");
      held_n   = niter;
      held_adr = adr_o;
      for (int i = 0; i < 20; i++) begin
         in_vld = 1'b1;
         x_man  = FPW'($urandom);
         y_man  = FPW'($urandom);
         adr_i  = AW'($urandom);
         @(posedge clk);
         @(negedge clk);
         chk("stall_vld", 64'(out_vld), 64'd1);
         chk("stall_niter", 64'(niter), 64'(held_n));
         chk("stall_adr", 64'(adr_o), 64'(held_adr));
         chk("stall_in_rdy", 64'(in_rdy), 64'd0);
      end
      in_vld  = 1'b0;
      out_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("stall_release_vld", 64'(out_vld), 64'd0);
      chk("stall_release_rdy", 64'(in_rdy), 64'd1);
      @(posedge clk);
      @(negedge clk);
      chk("stall_no_ghost", 64'(out_vld), 64'd0);

      run_point(-ONE, ONE / 4, 11'h055, 1'b1, "clken_half");

      // Reset in the middle of a long calculation
      in_vld = 1'b1;
      x_man  = '0;
      y_man  = '0;
      adr_i  = 11'h6B6;
      @(posedge clk);
      @(negedge clk);
      in_vld = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_vld", 64'(out_vld), 64'd0);
      chk("abort_rdy", 64'(in_rdy), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_niter", 64'(niter), 64'd0);
      chk("abort_adr", 64'(adr_o), 64'd0);
      chk("abort_idle", 64'(out_vld), 64'd0);

      run_point(ONE / 4, -ONE / 2, 11'h001, 1'b0, "b2b_a");
      run_point(-ONE / 2 - ONE / 8, ONE / 2, 11'h7FF, 1'b0, "b2b_b");

      for (int k = 0; k < 12; k++) begin
         rx = int'($urandom_range(0, 14680064)) - 10485760;
         ry = int'($urandom_range(0, 12582912)) - 6291456;
         run_point(rx, ry, AW'($urandom), 1'b0, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
